i2c_bus_arbiter: RTL and testbench

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

---
 rtl/i2c_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module : i2c_bus_arbiter
// Desc   : Round-robin arbiter sharing one I2C driver between two masters.
//          Optional idle watchdog is enabled by defining I2C_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
//==============================================================================
module i2c_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CTR_SIZE       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  m_ena,
  input  logic [1:0]  m_rw,
  input  logic [1:0]  m_start,
  input  logic [1:0]  m_stop,
  input  logic [1:0]  m_rstart,
  input  logic [15:0] m_data_wr,
  output logic [7:0]  m_data_rd,
  output logic [1:0]  m_busy,
  output logic [1:0]  m_ready,
  output logic [1:0]  m_ack_err,
  output logic        drv_ena,
  output logic        drv_rw,
  output logic        drv_start,
  output logic        drv_stop,
  output logic        drv_r_start,
  output logic [7:0]  drv_data_wr,
  input  logic        drv_busy,
  input  logic        drv_ready,
  input  logic        drv_ack_err,
  input  logic [7:0]  drv_data_rd
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_owner;
  logic       r_last_owner;
  logic [1:0] r_gnt;

  logic w_granted;
  logic w_pick;
  logic w_timeout;
  logic w_release;

  if (CTR_SIZE < 1 || CTR_SIZE > 31 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > (1 << CTR_SIZE)) begin : g_bad_cfg
    $error("i2c_bus_arbiter: TIMEOUT_CYCLES does not fit in CTR_SIZE");
  end

  assign w_granted = (r_state == ST_GRANTED);
  // On a tie the master that did not own the bus last time wins.
  assign w_pick    = (&req) ? ~r_last_owner : req[1];
  assign w_release = w_granted && ((!req[r_owner] && !drv_busy) || w_timeout);

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [CTR_SIZE-1:0] c_wd_max = CTR_SIZE'(TIMEOUT_CYCLES - 1);

  logic [CTR_SIZE-1:0] r_wd;
  logic                w_owner_quiet;

  assign w_owner_quiet = !drv_busy && !m_ena[r_owner];
  assign w_timeout     = w_granted && w_owner_quiet && (r_wd == c_wd_max);

  always_ff @(posedge clk) begin
    if (rst || !w_granted || !w_owner_quiet || w_release) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + {{(CTR_SIZE-1){1'b0}}, 1'b1};
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 2'b00;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state      <= ST_GRANTED;
            r_owner      <= w_pick;
            r_last_owner <= w_pick;
            r_gnt        <= w_pick ? 2'b10 : 2'b01;
          end
        end
        ST_GRANTED: begin
          if (w_release) begin
            r_state <= ST_RELEASE;
            r_gnt   <= 2'b00;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_gnt   <= 2'b00;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign m_data_rd = drv_data_rd;

  always_comb begin
    drv_ena     = 1'b0;
    drv_rw      = 1'b0;
    drv_start   = 1'b0;
    drv_stop    = 1'b0;
    drv_r_start = 1'b0;
    drv_data_wr = 8'h00;
    m_busy      = 2'b11;
    m_ready     = 2'b00;
    m_ack_err   = 2'b00;
    if (w_granted) begin
      drv_ena            = m_ena[r_owner];
      drv_rw             = m_rw[r_owner];
      drv_start          = m_start[r_owner];
      drv_stop           = m_stop[r_owner];
      drv_r_start        = m_rstart[r_owner];
      drv_data_wr        = r_owner ? m_data_wr[15:8] : m_data_wr[7:0];
      m_busy[r_owner]    = drv_busy;
      m_ready[r_owner]   = drv_ready;
      m_ack_err[r_owner] = drv_ack_err | w_timeout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module : tb_i2c_bus_arbiter
// Desc   : Directed and randomized checks of i2c_bus_arbiter against a model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_i2c_bus_arbiter;

  localparam int TB_TIMEOUT = 16;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit TB_WD = 1'b1;
`else
  localparam bit TB_WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, m_ena, m_rw, m_start, m_stop, m_rstart;
  logic [15:0] m_data_wr;
  logic        drv_busy, drv_ready, drv_ack_err;
  logic [7:0]  drv_data_rd;
  logic [1:0]  gnt, m_busy, m_ready, m_ack_err;
  logic [7:0]  m_data_rd, drv_data_wr;
  logic        drv_ena, drv_rw, drv_start, drv_stop, drv_r_start;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the bus, whether the one-cycle gap is running,
  // who won last, and how long the owner has been quiet.
  int mdl_owner   = -1;
  bit mdl_gap     = 1'b0;
  int mdl_last    = 1;
  int mdl_quiet   = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CTR_SIZE(17)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .m_ena(m_ena), .m_rw(m_rw), .m_start(m_start), .m_stop(m_stop),
    .m_rstart(m_rstart), .m_data_wr(m_data_wr), .m_data_rd(m_data_rd),
    .m_busy(m_busy), .m_ready(m_ready), .m_ack_err(m_ack_err),
    .drv_ena(drv_ena), .drv_rw(drv_rw), .drv_start(drv_start),
    .drv_stop(drv_stop), .drv_r_start(drv_r_start), .drv_data_wr(drv_data_wr),
    .drv_busy(drv_busy), .drv_ready(drv_ready), .drv_ack_err(drv_ack_err),
    .drv_data_rd(drv_data_rd)
  );

  function automatic bit mdl_timeout_now();
    if (!TB_WD || mdl_owner < 0) return 1'b0;
    return !drv_busy && !m_ena[mdl_owner] && (mdl_quiet == TB_TIMEOUT - 1);
  endfunction

  task automatic mdl_step();
    bit quiet;
    if (rst) begin
      mdl_owner = -1; mdl_gap = 1'b0; mdl_last = 1; mdl_quiet = 0;
    end else if (mdl_gap) begin
      mdl_gap = 1'b0;
    end else if (mdl_owner < 0) begin
      if (req != 2'b00) begin
        mdl_owner = (req == 2'b11) ? 1 - mdl_last : (req[1] ? 1 : 0);
        mdl_last  = mdl_owner;
        mdl_quiet = 0;
      end
    end else begin
      quiet = !drv_busy && !m_ena[mdl_owner];
      if ((!req[mdl_owner] && !drv_busy) || mdl_timeout_now()) begin
        mdl_owner = -1; mdl_gap = 1'b1; mdl_quiet = 0;
      end else begin
        mdl_quiet = quiet ? mdl_quiet + 1 : 0;
      end
    end
  endtask

  // Advance one clock; inputs are changed only on the falling edge.
  task automatic cycle();
    @(posedge clk);
    mdl_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = 2'b00; m_ena = 2'b00; m_rw = 2'b00; m_start = 2'b00; m_stop = 2'b00;
    m_rstart = 2'b00; m_data_wr = 16'h0000; drv_busy = 1'b0; drv_ready = 1'b0;
    drv_ack_err = 1'b0; drv_data_rd = 8'h00;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic go_idle();
    clear_inputs();
    repeat (3) cycle();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    m_ena = 2'b11; m_start = 2'b11; m_data_wr = 16'hA5C3; req = 2'b11;
    cycle();
    cycle();
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if ({drv_ena, drv_rw, drv_start, drv_stop, drv_r_start, drv_data_wr} !== 13'h0) begin
      errors++; $display("FAIL reset_drv got=%h exp=0", {drv_ena, drv_rw, drv_start, drv_stop, drv_r_start, drv_data_wr}); end
    checks++; if ({m_busy, m_ready, m_ack_err} !== 6'b11_00_00) begin
      errors++; $display("FAIL reset_master got=%b exp=110000", {m_busy, m_ready, m_ack_err}); end
    rst = 1'b0;
    clear_inputs();
    #1;
  endtask

  task automatic test_single_grant();
    go_idle();
    req = 2'b01; m_data_wr = 16'h55EE;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_pre gnt got=%b exp=00", gnt); end
    cycle();
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    checks++; if (drv_data_wr !== 8'hEE) begin errors++; $display("FAIL single_data got=%h exp=ee", drv_data_wr); end
    checks++; if (m_busy !== 2'b10) begin errors++; $display("FAIL single_busy got=%b exp=10", m_busy); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req = 2'b11;
    cycle(); #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rr_first got=%b exp=01", gnt); end
    req = 2'b10;
    cycle(); #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr_release got=%b exp=00", gnt); end
    cycle(); #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr_idle got=%b exp=00", gnt); end
    cycle(); #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rr_second got=%b exp=10", gnt); end
    req = 2'b00;
    cycle(); cycle();
    req = 2'b11;
    cycle(); #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rr_third got=%b exp=01", gnt); end
  endtask

  task automatic test_busy_hold();
    int held;
    go_idle();
    req = 2'b01;
    cycle();
    drv_busy = 1'b1; m_ena = 2'b01; req = 2'b00;
    held = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(); #1;
      if (gnt === 2'b01 && m_busy === 2'b11) held++;
    end
    checks++; if (held !== 40) begin errors++; $display("FAIL busy_hold cycles got=%0d exp=40", held); end
    drv_busy = 1'b0; m_ena = 2'b00;
    cycle(); #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL busy_release got=%b exp=00", gnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 2'b01; m_ena = 2'b01;
    cycle(); #1;
    checks++; if (drv_ena !== 1'b1) begin errors++; $display("FAIL mid_ena_on got=%b exp=1", drv_ena); end
    rst = 1'b1;
    cycle(); #1;
    checks++; if ({gnt, drv_ena, m_busy} !== 5'b00_0_11) begin
      errors++; $display("FAIL mid_reset got=%b exp=00011", {gnt, drv_ena, m_busy}); end
    rst = 1'b0; req = 2'b11;
    cycle(); #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_tie got=%b exp=01", gnt); end
  endtask

  task automatic test_timeout();
    logic [1:0] exp_ack;
    go_idle();
    req = 2'b01;
    cycle();
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      #1;
      exp_ack = (k == TB_TIMEOUT) ? 2'b01 : 2'b00;
      checks++; if (m_ack_err !== exp_ack) begin
        errors++; $display("FAIL timeout_ack k=%0d got=%b exp=%b", k, m_ack_err, exp_ack); end
      cycle();
    end
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL timeout_release got=%b exp=00", gnt); end
  endtask

  task automatic test_random();
    logic [1:0]  e_gnt, e_busy, e_ready, e_ack;
    logic [12:0] e_drv;
    int          o;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) < 3) req = 2'($urandom);
      m_ena = 2'($urandom); m_rw = 2'($urandom); m_start = 2'($urandom);
      m_stop = 2'($urandom); m_rstart = 2'($urandom); m_data_wr = 16'($urandom);
      if ($urandom_range(0, 9) < 4) drv_busy = 1'($urandom);
      drv_ready = 1'($urandom); drv_ack_err = 1'($urandom); drv_data_rd = 8'($urandom);
      #1;
      o = mdl_owner;
      e_gnt = 2'b00; e_busy = 2'b11; e_ready = 2'b00; e_ack = 2'b00; e_drv = '0;
      if (o >= 0) begin
        e_gnt[o]   = 1'b1;
        e_busy[o]  = drv_busy;
        e_ready[o] = drv_ready;
        e_ack[o]   = drv_ack_err | mdl_timeout_now();
        e_drv = {m_ena[o], m_rw[o], m_start[o], m_stop[o], m_rstart[o],
                 (o == 1) ? m_data_wr[15:8] : m_data_wr[7:0]};
      end
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, gnt, e_gnt); end
      checks++; if ({drv_ena, drv_rw, drv_start, drv_stop, drv_r_start, drv_data_wr} !== e_drv) begin
        errors++; $display("FAIL rnd_drv n=%0d got=%h exp=%h", n,
          {drv_ena, drv_rw, drv_start, drv_stop, drv_r_start, drv_data_wr}, e_drv); end
      checks++; if ({m_busy, m_ready, m_ack_err} !== {e_busy, e_ready, e_ack}) begin
        errors++; $display("FAIL rnd_master n=%0d got=%b exp=%b", n,
          {m_busy, m_ready, m_ack_err}, {e_busy, e_ready, e_ack}); end
      checks++; if (m_data_rd !== drv_data_rd) begin
        errors++; $display("FAIL rnd_rd n=%0d got=%h exp=%h", n, m_data_rd, drv_data_rd); end
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_grant();
    test_round_robin();
    test_busy_hold();
    test_reset_mid();
    if (TB_WD) test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
